// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_pkg: PWM register map, control bits, ramp FSM states and step arithmetic
package pwm_pkg;
  localparam logic [3:0] ADR_CTRL = 4'h0;
  localparam logic [3:0] ADR_DIV = 4'h2;
  localparam logic [3:0] ADR_PER = 4'h4;
  localparam logic [3:0] ADR_DC = 4'h6;
  localparam int CTRL_MODE_PWM = 1;
  localparam int CTRL_CNT_EN = 2;
  localparam int CTRL_CONT = 3;
  localparam int CTRL_OUT_EN = 4;
  localparam logic [7:0] CTRL_RUN_DEF = (8'd1 << CTRL_MODE_PWM) | (8'd1 << CTRL_CNT_EN) |
                                        (8'd1 << CTRL_CONT) | (8'd1 << CTRL_OUT_EN);
  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_DIV, WR_PER, WR_DC, WR_RUN, DWELL, STEP, DONE, WR_ABORT
  } state_t;
  function automatic logic [15:0] next_dc(input logic [15:0] cur, tgt, step);
    logic [16:0] up, dn;
    up = {1'b0, cur} + {1'b0, step};
    dn = {1'b0, cur} - {1'b0, step};
    return tgt > cur ? (up > {1'b0, tgt} ? tgt : up[15:0])
                     : (dn[16] || dn[15:0] < tgt ? tgt : dn[15:0]);
  endfunction
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: write-only 16-bit Wishbone link to the PWM peripheral
interface pwm_ramp_ctrl_if;
  logic cyc, stb, we, ack;
  logic [3:0] adr;
  logic [15:0] dat;
  modport master(output cyc, stb, we, adr, dat, input ack);
  modport slave(input cyc, stb, we, adr, dat, output ack);
endinterface

// File: rtl/pwm_ramp_ctrl_wb_single_writer.sv
// wb_single_writer: issues one registered Wishbone write, reports ack or ack timeout
module wb_single_writer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [3:0]  i_adr,
  input  logic [15:0] i_data,
  pwm_ramp_ctrl_if.master wb,
  output logic        o_done,
  output logic        o_timeout
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign o_done = wb.cyc && wb.ack;
  assign o_timeout = wb.cyc && !wb.ack && cnt == CW'(ACK_TIMEOUT - 1);
  // hold cyc/stb/we with stable adr/data until ack or timeout, then drop for at least one cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wb.cyc <= 1'b0;
      wb.stb <= 1'b0;
      wb.we <= 1'b0;
      wb.adr <= '0;
      wb.dat <= '0;
      cnt <= '0;
    end else if (o_done || o_timeout) begin
      wb.cyc <= 1'b0;
      wb.stb <= 1'b0;
      wb.we <= 1'b0;
    end else if (i_req && !wb.cyc) begin
      wb.cyc <= 1'b1;
      wb.stb <= 1'b1;
      wb.we <= 1'b1;
      wb.adr <= i_adr;
      wb.dat <= i_data;
      cnt <= '0;
    end else if (wb.cyc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: programs a PWM peripheral and ramps its duty cycle over Wishbone
module pwm_ramp_ctrl import pwm_pkg::*; #(
  parameter logic [7:0] CTRL_RUN = CTRL_RUN_DEF,
  parameter int ACK_TIMEOUT = 16,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [15:0]   i_divisor,
  input  logic [15:0]   i_period,
  input  logic [15:0]   i_dc_start,
  input  logic [15:0]   i_dc_target,
  input  logic [15:0]   i_step,
  input  logic [DW-1:0] i_dwell,
  pwm_ramp_ctrl_if.master wb,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_cur_dc
);
  state_t state, state_n;
  logic [15:0] div_q, per_q, tgt_q, step_q, nxt_q, dat;
  logic [DW-1:0] dwell_q, dcnt;
  logic [3:0] adr;
  logic run_q, abort_q, bad, wr_st, abrt, req, wr_done, wr_to;
  assign bad = i_period == 16'd0 || i_dc_start > i_period || i_dc_target > i_period ||
               (i_step == 16'd0 && i_dc_start != i_dc_target);
  assign wr_st = state inside {WR_STOP, WR_DIV, WR_PER, WR_DC, WR_RUN, WR_ABORT};
  assign abrt = (i_abort || abort_q) && !(state inside {IDLE, DONE, WR_ABORT});
  assign req = wr_st && !wb.cyc && !abrt;
  assign adr = state == WR_DIV ? ADR_DIV : state == WR_PER ? ADR_PER :
               state == WR_DC ? ADR_DC : ADR_CTRL;
  assign dat = state == WR_DIV ? div_q : state == WR_PER ? per_q : state == WR_DC ? nxt_q :
               state == WR_RUN ? {8'h00, CTRL_RUN} : 16'h0000;
  assign o_done = state == DONE;
  assign o_busy = !(state inside {IDLE, DONE});
  wb_single_writer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wr (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req(req),
    .i_adr(adr),
    .i_data(dat),
    .wb(wb),
    .o_done(wr_done),
    .o_timeout(wr_to)
  );
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  // sequencing: setup writes, dwell/step loop; abort waits out an in-flight write, timeout wins over all
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = i_start && !bad ? WR_STOP : IDLE;
      WR_STOP: if (wr_done) state_n = WR_DIV;
      WR_DIV: if (wr_done) state_n = WR_PER;
      WR_PER: if (wr_done) state_n = WR_DC;
      WR_DC: if (wr_done) state_n = !run_q ? WR_RUN : nxt_q == tgt_q ? DONE :
                                    dwell_q != '0 ? DWELL : STEP;
      WR_RUN: if (wr_done) state_n = o_cur_dc == tgt_q ? DONE : dwell_q != '0 ? DWELL : STEP;
      DWELL: if (dcnt == dwell_q - 1'b1) state_n = STEP;
      STEP: state_n = WR_DC;
      DONE: state_n = IDLE;
      WR_ABORT: if (wr_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abrt && (!wb.cyc || wr_done)) state_n = WR_ABORT;
    if (wr_to) state_n = IDLE;
  end
  // configuration capture, ramp datapath, abort latch and error pulse
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      div_q <= '0;
      per_q <= '0;
      tgt_q <= '0;
      step_q <= '0;
      nxt_q <= '0;
      dwell_q <= '0;
      dcnt <= '0;
      run_q <= 1'b0;
      abort_q <= 1'b0;
      o_err <= 1'b0;
      o_cur_dc <= '0;
    end else begin
      if (state == IDLE && i_start && !bad) begin
        div_q <= i_divisor;
        per_q <= i_period;
        tgt_q <= i_dc_target;
        step_q <= i_step;
        nxt_q <= i_dc_start;
        dwell_q <= i_dwell;
        run_q <= 1'b0;
      end
      if (state == WR_DC && wr_done) o_cur_dc <= nxt_q;
      if (state == WR_RUN && wr_done) run_q <= 1'b1;
      if (state == STEP) nxt_q <= next_dc(o_cur_dc, tgt_q, step_q);
      dcnt <= state == DWELL ? dcnt + 1'b1 : '0;
      abort_q <= state != IDLE && (abort_q || i_abort);
      o_err <= wr_to || (state == IDLE && i_start && bad);
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed and random ramps against a write-list reference model
module tb_pwm_ramp_ctrl;
  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_abort = 0;
  logic [15:0] i_divisor = 0, i_period = 0, i_dc_start = 0, i_dc_target = 0, i_step = 0;
  logic [23:0] i_dwell = 0;
  logic o_busy, o_done, o_err;
  logic [15:0] o_cur_dc;
  pwm_ramp_ctrl_if wb();
  pwm_ramp_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_divisor(i_divisor), .i_period(i_period), .i_dc_start(i_dc_start),
    .i_dc_target(i_dc_target), .i_step(i_step), .i_dwell(i_dwell), .wb(wb),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_cur_dc(o_cur_dc)
  );
  always #5 i_clk = ~i_clk;

  int tests = 0, fails = 0;
  int lat = 1, hold_idx = -1, wr_idx = 0, lat_cnt = 0, hold_cycles = 0, done_cnt = 0, err_cnt = 0;
  bit busy_seen = 0, cyc_seen = 0, we_bad = 0;
  logic [19:0] obs_q[$], exp_q[$];

  // slave model and event monitor, sampled on the falling edge
  initial begin
    wb.ack = 0;
    forever begin
      @(negedge i_clk);
      if (wb.ack) wb.ack = 0;
      else if (wb.cyc && wb.stb) begin
        if (wr_idx == hold_idx) hold_cycles++;
        else if (++lat_cnt >= lat) begin
          wb.ack = 1;
          obs_q.push_back({wb.adr, wb.dat});
          if (!wb.we) we_bad = 1;
          wr_idx++;
          lat_cnt = 0;
        end
      end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      if (o_busy) busy_seen = 1;
      if (wb.cyc) cyc_seen = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic go(input logic [15:0] d, p, s, t, st, input logic [23:0] dw, input bit ab);
    obs_q.delete();
    wr_idx = 0; lat_cnt = 0; hold_idx = -1; hold_cycles = 0;
    done_cnt = 0; err_cnt = 0; busy_seen = 0; cyc_seen = 0; we_bad = 0;
    i_divisor = d; i_period = p; i_dc_start = s; i_dc_target = t; i_step = st; i_dwell = dw;
    i_start = 1; i_abort = ab;
    tick();
    i_start = 0; i_abort = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) tick();
    while ((o_busy || wb.cyc) && n < 5000) begin tick(); n++; end
    repeat (3) tick();
    chk({tag, "_idle"}, 32'(o_busy | wb.cyc), 0);
  endtask

  // expected write list: setup sequence, then clamped steps toward target
  task automatic model(input logic [15:0] d, p, s, t, st);
    int cur, tg, sz;
    exp_q.delete();
    exp_q.push_back({4'h0, 16'h0000});
    exp_q.push_back({4'h2, d});
    exp_q.push_back({4'h4, p});
    exp_q.push_back({4'h6, s});
    exp_q.push_back({4'h0, 16'h001E});
    cur = int'(s); tg = int'(t); sz = int'(st);
    while (cur != tg) begin
      if (tg > cur) cur = (cur + sz >= tg) ? tg : cur + sz;
      else cur = (cur - sz <= tg) ? tg : cur - sz;
      exp_q.push_back({4'h6, 16'(cur)});
    end
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic full_run(input string tag, input logic [15:0] d, p, s, t, st,
                          input logic [23:0] dw, input bit ab);
    bit ok;
    ok = p != 0 && s <= p && t <= p && !(st == 0 && s != t);
    go(d, p, s, t, st, dw, ab);
    wait_idle(tag);
    if (ok) begin
      model(d, p, s, t, st);
      cmp_writes(tag);
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_err"}, err_cnt, 0);
      chk({tag, "_cur"}, 32'(o_cur_dc), 32'(t));
      chk({tag, "_we"}, 32'(we_bad), 0);
    end else begin
      chk({tag, "_err"}, err_cnt, 1);
      chk({tag, "_cyc"}, 32'(cyc_seen), 0);
      chk({tag, "_busy"}, 32'(busy_seen), 0);
      chk({tag, "_done"}, done_cnt, 0);
    end
  endtask

  initial begin
    int n;
    logic [15:0] p, s, t, st;
    repeat (3) tick();
    chk("rst_cyc", 32'(wb.cyc), 0);
    chk("rst_stb", 32'(wb.stb), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_cur", 32'(o_cur_dc), 0);
    i_rst_n = 1;
    tick();

    full_run("up", 4, 1000, 100, 500, 150, 10, 0);
    full_run("down", 4, 1000, 900, 50, 400, 3, 0);
    full_run("equal", 4, 1000, 300, 300, 0, 5, 0);
    full_run("reject", 4, 1000, 100, 1200, 50, 2, 0);
    full_run("start_abort", 7, 800, 0, 800, 300, 1, 1);

    go(4, 1000, 100, 500, 150, 10, 0);
    hold_idx = 1;
    wait_idle("tmo");
    chk("tmo_err", err_cnt, 1);
    chk("tmo_done", done_cnt, 0);
    chk("tmo_cycles", hold_cycles, 16);
    chk("tmo_nwr", obs_q.size(), 1);
    full_run("after_tmo", 4, 1000, 100, 500, 150, 2, 0);

    lat = 4;
    go(9, 600, 10, 590, 100, 2, 0);
    n = 0;
    while (!(wr_idx == 2 && wb.cyc) && n < 500) begin tick(); n++; end
    chk("abf_wait", 32'(wr_idx == 2 && wb.cyc), 1);
    i_abort = 1; tick(); i_abort = 0;
    wait_idle("abf");
    exp_q = '{{4'h0, 16'h0000}, {4'h2, 16'd9}, {4'h4, 16'd600}, {4'h0, 16'h0000}};
    cmp_writes("abf");
    chk("abf_done", done_cnt, 0);

    lat = 1;
    go(4, 1000, 100, 500, 150, 40, 0);
    n = 0;
    while (o_cur_dc != 250 && n < 500) begin tick(); n++; end
    chk("abd_wait", 32'(o_cur_dc), 250);
    repeat (3) tick();
    i_abort = 1; tick(); i_abort = 0;
    wait_idle("abd");
    exp_q = '{{4'h0, 16'h0000}, {4'h2, 16'd4}, {4'h4, 16'd1000}, {4'h6, 16'd100},
              {4'h0, 16'h001E}, {4'h6, 16'd250}, {4'h0, 16'h0000}};
    cmp_writes("abd");
    chk("abd_done", done_cnt, 0);
    chk("abd_cur", 32'(o_cur_dc), 250);

    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(1, 3);
      p = 16'($urandom_range(1, 3000));
      s = 16'($urandom_range(0, int'(p)));
      t = ($urandom_range(0, 3) == 0) ? 16'(int'(p) + 1 + $urandom_range(0, 50))
                                      : 16'($urandom_range(0, int'(p)));
      st = (s == t && $urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(int'(p) / 6 + 1, int'(p) + 100));
      full_run($sformatf("rnd%0d", i), 16'($urandom_range(0, 65535)), p, s, t, st,
               24'($urandom_range(0, 4)), 0);
    end

    lat = 6;
    go(4, 1000, 100, 500, 150, 10, 0);
    n = 0;
    while (!wb.cyc && n < 100) begin tick(); n++; end
    chk("mrst_wait", 32'(wb.cyc), 1);
    #2 i_rst_n = 0;
    #1;
    chk("mrst_cyc", 32'(wb.cyc), 0);
    chk("mrst_stb", 32'(wb.stb), 0);
    chk("mrst_we", 32'(wb.we), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_done", 32'(o_done), 0);
    chk("mrst_err", 32'(o_err), 0);
    chk("mrst_cur", 32'(o_cur_dc), 0);
    repeat (2) tick();
    i_rst_n = 1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Wishbone master that programs one PWM/timer peripheral and ramps its duty cycle from a start value to a target value in fixed steps with a programmable dwell between steps. It sits between system control logic (one start/abort request interface) and the PWM peripheral's 16-bit Wishbone slave port. It removes per-step CPU writes for soft-start and fade profiles.

Parameters:
CTRL_RUN, 8'h1E, control word written to start the PWM (bit1 mode=PWM, bit2 counter_en, bit3 continuous, bit4 pwm_out_en; bit0/5/6/7 = 0)
ACK_TIMEOUT, 16, max cycles to wait for i_wb_ack per bus write before error
DW, 24, width of dwell counter/input

Ports:
i_clk  input  1  system clock; also the Wishbone clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  1-cycle start request; sampled only in IDLE
i_abort  input  1  abort request; honoured in any non-IDLE state
i_divisor  input  16  clock divisor value to program
i_period  input  16  period value to program
i_dc_start  input  16  initial duty cycle
i_dc_target  input  16  final duty cycle
i_step  input  16  duty-cycle increment per step (magnitude)
i_dwell  input  DW  cycles to wait after each DC write ack before the next step
o_wb_cyc  output  1  Wishbone cycle
o_wb_stb  output  1  Wishbone strobe
o_wb_we  output  1  write enable (always 1 when o_wb_stb=1)
o_wb_adr  output  4  register byte address
o_wb_data  output  16  write data
i_wb_ack  input  1  slave acknowledge
o_busy  output  1  high from accepted start until return to IDLE
o_done  output  1  1-cycle pulse: target reached and written
o_err  output  1  1-cycle pulse: rejected start or ack timeout
o_cur_dc  output  16  last DC value acknowledged by the slave

Behaviour:
- Clock i_clk; reset asynchronous, active-low. Reset: all outputs 0, o_cur_dc=0, FSM=IDLE. Reset mid-transaction drops o_wb_cyc/o_wb_stb immediately; no completion.
- Slave register map (byte addr): 0x0 ctrl[7:0], 0x2 divisor, 0x4 period, 0x6 duty cycle.
- Start: i_start in IDLE latches all config inputs. Reject (o_err pulse next cycle, no bus activity, stay IDLE) if i_period==0, i_dc_start>i_period, i_dc_target>i_period, or i_step==0 with i_dc_start!=i_dc_target.
- States: IDLE -> WR_STOP (ctrl=0x00) -> WR_DIV -> WR_PER -> WR_DC (dc=start) -> WR_RUN (ctrl=CTRL_RUN) -> DWELL -> STEP -> WR_DC ... -> DONE -> IDLE.
- Bus write: registered outputs; cyc=stb=we=1 with stable adr/data from first cycle until the cycle i_wb_ack=1 is sampled; deassert cyc/stb next cycle; at least one idle bus cycle between writes. One write outstanding max.
- Timeout: counter resets per write; if ACK_TIMEOUT cycles pass without ack, drop cyc/stb, pulse o_err, go IDLE (no stop write attempted).
- o_cur_dc updates on ack of every DC write.
- After WR_RUN ack: if cur==target -> DONE. Else DWELL counts i_dwell cycles (i_dwell=0 -> zero-cycle dwell, straight to STEP).
- STEP: up if target>cur: next=min(cur+step, target); down: next=max(cur-step, target). Compute in 17 bits; no wrap; final step clamped exactly to target. After DC ack: if next==target -> DONE, else DWELL.
- DONE: o_done pulse, o_busy falls same cycle, IDLE next.
- Abort: i_abort in any non-IDLE state: if a write is in flight, wait for its ack (timeout still applies); then write ctrl=0x00 (WR_ABORT), then IDLE; no o_done. Abort and start both high in IDLE: start wins, abort ignored. Abort in DWELL exits immediately to WR_ABORT.
- i_start while busy ignored.

Decomposition:
- Shared package pwm_pkg: register byte addresses (ADR_CTRL, ADR_DIV, ADR_PER, ADR_DC), ctrl bit index constants, FSM state enum.
- One sub-module wb_single_writer: issues one write, handles ack/timeout, reports done/timeout; FSM above drives it.

Test Plan:
- Ramp up: div=4, per=1000, start=100, target=500, step=150, dwell=10, ack after 1 cycle -> writes 0x0=0,0x2=4,0x4=1000,0x6=100,0x0=0x1E, then DC 250,400,500; o_done once; o_cur_dc=500.
- Ramp down clamp: start=900, target=50, step=400 -> DC writes 900,500,100,50; no underflow.
- start==target=300, step=0 -> five setup writes only, o_done after ctrl ack, no DWELL.
- Reject: per=1000, target=1200 -> o_err pulse, o_wb_cyc never asserted, o_busy stays 0.
- Timeout: slave withholds ack on divisor write -> o_err after 16 cycles, cyc/stb low, IDLE; next valid start completes normally.
- Abort in DWELL after DC=250 -> next write ctrl 0x00, then IDLE, no o_done, o_cur_dc=250; reset asserted mid-write -> all outputs 0 immediately.
